// File: rtl/baseline_sched_pkg.sv
// baseline_sched_pkg: shared state encoding and width helpers for the baseline scheduler
package baseline_sched_pkg;
  typedef enum logic [2:0] {IDLE, SELECT, SETTLE, ACCUM, LATCH, NEXT} sched_state_t;
  localparam int ACC_W_DEFAULT = 12 + 10;
  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic int acc_w(input int width, input int avg_log2);
    return width + avg_log2;
  endfunction
endpackage

// File: rtl/baseline_accumulator.sv
// baseline_accumulator: signed running sum with sample counter and reached-N flag
module baseline_accumulator #(
  parameter int WIDTH = 12,
  parameter int AVG_LOG2 = 10
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               clear,
  input  logic                               add_en,
  input  logic [WIDTH-1:0]                   data,
  output logic signed [WIDTH+AVG_LOG2-1:0]   sum,
  output logic [AVG_LOG2:0]                  count,
  output logic                               full
);
  assign full = count[AVG_LOG2];
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      sum <= '0;
      count <= '0;
    end else if (add_en) begin
      sum <= sum + {{AVG_LOG2{data[WIDTH-1]}}, data};
      count <= count + 1'b1;
    end
  end
endmodule

// File: rtl/baseline_scheduler.sv
// baseline_scheduler: round-robin shared baseline averager; BASELINE_SCHED_ROUNDING_EN selects round-half-up
module baseline_scheduler
  import baseline_sched_pkg::*;
#(
  parameter int WIDTH = 12,
  parameter int NCH = 4,
  parameter int AVG_LOG2 = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sample_en,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     continuous,
  input  logic [15:0]              settle_samples,
  input  logic [NCH-1:0]           ch_enable,
  input  logic [NCH*WIDTH-1:0]     data_in,
  output logic [NCH*WIDTH-1:0]     baseline_out,
  output logic [NCH-1:0]           baseline_valid,
  output logic [$clog2(NCH)-1:0]   cur_ch,
  output logic                     busy,
  output logic                     pass_done,
  output logic                     cfg_error
);
  localparam int IW = ch_idx_w(NCH);
  localparam int ACC_W = acc_w(WIDTH, AVG_LOG2);
  sched_state_t state, state_n;
  logic [IW:0] ptr;
  logic [15:0] settle_cnt;
  logic found;
  logic [IW-1:0] pick;
  logic signed [ACC_W-1:0] sum;
  logic [AVG_LOG2:0] count;
  logic full;
  logic [NCH-1:0][WIDTH-1:0] base_q;
  logic [WIDTH-1:0] mean;
  assign busy = state != IDLE;
  assign baseline_out = base_q;
  baseline_accumulator #(.WIDTH(WIDTH), .AVG_LOG2(AVG_LOG2)) u_acc (
    .clk(clk),
    .reset(reset),
    .clear(state == SELECT),
    .add_en(state == ACCUM && sample_en && !count[AVG_LOG2]),
    .data(data_in[cur_ch*WIDTH +: WIDTH]),
    .sum(sum),
    .count(count),
    .full(full)
  );
`ifdef BASELINE_SCHED_ROUNDING_EN
  logic signed [ACC_W:0] rsum;
  logic [WIDTH:0] q;
  assign rsum = {sum[ACC_W-1], sum} + (ACC_W+1)'(1 << (AVG_LOG2 - 1));
  assign q = (WIDTH+1)'(rsum >>> AVG_LOG2);
  assign mean = (q[WIDTH] == q[WIDTH-1]) ? q[WIDTH-1:0] : {q[WIDTH], {(WIDTH-1){~q[WIDTH]}}};
`else
  assign mean = WIDTH'(sum >>> AVG_LOG2);
`endif
  // lowest enabled channel at or above the scan pointer
  always_comb begin
    found = 1'b0;
    pick = '0;
    for (int k = NCH - 1; k >= 0; k--)
      if (ch_enable[k] && (IW+1)'(k) >= ptr) begin
        found = 1'b1;
        pick = IW'(k);
      end
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = (start && ch_enable != '0) ? SELECT : IDLE;
      SELECT:  state_n = found ? SETTLE : NEXT;
      SETTLE:  state_n = (settle_cnt == settle_samples) ? ACCUM : SETTLE;
      ACCUM:   state_n = full ? LATCH : ACCUM;
      LATCH:   state_n = SELECT;
      NEXT:    state_n = continuous ? SELECT : IDLE;
      default: state_n = IDLE;
    endcase
    if (abort) state_n = IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr <= '0;
      cur_ch <= '0;
      settle_cnt <= '0;
      base_q <= '0;
      baseline_valid <= '0;
      pass_done <= 1'b0;
      cfg_error <= 1'b0;
    end else begin
      state <= state_n;
      pass_done <= state_n == NEXT;
      if (state == IDLE && start && !abort) cfg_error <= ch_enable == '0;
      if (state == IDLE || state == NEXT) ptr <= '0;
      if (state == SELECT) begin
        settle_cnt <= '0;
        if (found) cur_ch <= pick;
      end
      if (state == SETTLE && sample_en && settle_cnt != settle_samples) settle_cnt <= settle_cnt + 16'd1;
      if (state == LATCH && !abort) begin
        base_q[cur_ch] <= mean;
        baseline_valid[cur_ch] <= 1'b1;
        ptr <= (IW+1)'(cur_ch) + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_baseline_scheduler.sv
// tb_baseline_scheduler: directed checks of the shared baseline scheduler (NCH=4, AVG_LOG2=4)
module tb_baseline_scheduler;
  localparam int W = 12;
  localparam int N = 4;
  localparam int A = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sample_en = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic continuous = 1'b0;
  logic [15:0] settle_samples = 16'd2;
  logic [N-1:0] ch_enable = '0;
  logic [N*W-1:0] data_in;
  logic [N*W-1:0] baseline_out;
  logic [N-1:0] baseline_valid;
  logic [1:0] cur_ch;
  logic busy, pass_done, cfg_error;
  logic signed [W-1:0] d0 = '0, d1 = '0, d2 = '0, d3 = '0, alt_val = -12'sd2;
  logic alt = 1'b0;
  int checks = 0;
  int failures = 0;
  int pass_cnt = 0;
  logic [N-1:0] seen = '0;
  logic busy_d = 1'b0;

  assign data_in = {d3, d2, d1, alt ? alt_val : d0};

  baseline_scheduler #(.WIDTH(W), .NCH(N), .AVG_LOG2(A)) dut (
    .clk(clk), .reset(reset), .sample_en(sample_en), .start(start), .abort(abort),
    .continuous(continuous), .settle_samples(settle_samples), .ch_enable(ch_enable),
    .data_in(data_in), .baseline_out(baseline_out), .baseline_valid(baseline_valid),
    .cur_ch(cur_ch), .busy(busy), .pass_done(pass_done), .cfg_error(cfg_error)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(negedge clk);
    if (!sample_en) begin
      sample_en = 1'b1;
      alt_val = (alt_val == -12'sd2) ? -12'sd3 : -12'sd2;
    end else sample_en = 1'b0;
  end

  always @(negedge clk) begin
    if (pass_done) pass_cnt++;
    if (busy && busy_d) seen[cur_ch] = 1'b1;
    busy_d = busy;
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int base(input int k);
    return int'($signed(baseline_out[k*W +: W]));
  endfunction

  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    step(1);
    pass_cnt = 0;
    seen = '0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int t = 0;
    while (busy && t < 3000) begin
      step();
      t++;
    end
    check(tag, int'(busy), 0);
  endtask

  task automatic wait_pass(input int n, input string tag);
    int t = 0;
    while (pass_cnt < n && t < 3000) begin
      step();
      t++;
    end
    check(tag, int'(pass_cnt >= n), 1);
  endtask

  initial begin
    int t;
    step(3);
    reset = 1'b0;
    step();
    check("rst_base", int'(baseline_out != '0), 0);
    check("rst_valid", int'(baseline_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_pass", int'(pass_done), 0);
    check("rst_cfg", int'(cfg_error), 0);
    check("rst_cur", int'(cur_ch), 0);

    d0 = 12'sd100; d1 = -12'sd50; d2 = 12'sd0; d3 = 12'sd2047;
    ch_enable = 4'b1111;
    pulse_start();
    check("p1_busy", int'(busy), 1);
    wait_idle("p1_idle");
    check("p1_b0", base(0), 100);
    check("p1_b1", base(1), -50);
    check("p1_b2", base(2), 0);
    check("p1_b3", base(3), 2047);
    check("p1_valid", int'(baseline_valid), 15);
    check("p1_passes", pass_cnt, 1);
    check("p1_cfg", int'(cfg_error), 0);

    do_reset();
    alt = 1'b1;
    d2 = 12'sd7;
    ch_enable = 4'b0101;
    pulse_start();
    wait_idle("sk_idle");
`ifdef BASELINE_SCHED_ROUNDING_EN
    check("sk_b0_round", base(0), -2);
`else
    check("sk_b0_trunc", base(0), -3);
`endif
    check("sk_b1", base(1), 0);
    check("sk_b2", base(2), 7);
    check("sk_b3", base(3), 0);
    check("sk_valid", int'(baseline_valid), 5);
    check("sk_seen", int'(seen), 5);
    alt = 1'b0;

    do_reset();
    ch_enable = 4'b1111;
    pulse_start();
    t = 0;
    while (!(busy && cur_ch == 2'd1) && t < 2000) begin
      step();
      t++;
    end
    check("ab_reach_ch1", int'(cur_ch), 1);
    step(12);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("ab_busy", int'(busy), 0);
    step(5);
    check("ab_valid", int'(baseline_valid), 1);
    check("ab_b0", base(0), 100);
    check("ab_b1", base(1), 0);
    check("ab_passes", pass_cnt, 0);

    ch_enable = 4'b0000;
    pulse_start();
    check("cfg_set", int'(cfg_error), 1);
    check("cfg_busy", int'(busy), 0);
    ch_enable = 4'b0001;
    pulse_start();
    check("cfg_clr", int'(cfg_error), 0);
    check("cfg_run", int'(busy), 1);
    wait_idle("cfg_idle");

    do_reset();
    ch_enable = 4'b0100;
    d2 = 12'sd10;
    continuous = 1'b1;
    pulse_start();
    wait_pass(1, "ct_pass1");
    check("ct_b2_first", base(2), 10);
    d2 = 12'sd20;
    wait_pass(2, "ct_pass2");
    continuous = 1'b0;
    check("ct_b2_second", base(2), 20);
    step();
    check("ct_busy", int'(busy), 0);
    check("ct_passes", pass_cnt, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/baseline_scheduler.md
Name: baseline_scheduler

Overview:
- Sequences one shared baseline accumulator across NCH detector channels, round-robin.
- Per enabled channel: waits a settle interval, sums 2^AVG_LOG2 samples, then latches the mean into that channel's baseline register.
- Baseline registers feed the per-channel subtractors ahead of the trigger logic.
- Replaces per-channel accumulators, trading update rate for area.

Parameters:
- WIDTH, 12, signed sample width.
- NCH, 4, number of channels (2..16).
- AVG_LOG2, 10, log2 of samples averaged per channel.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- sample_en  in  1  one-cycle strobe; a new sample is valid on all channels
- start  in  1  pulse; begin a calibration pass
- abort  in  1  pulse; stop and return to IDLE
- continuous  in  1  1 = restart a pass automatically after the last channel
- settle_samples  in  16  strobes discarded after each channel switch
- ch_enable  in  NCH  channel participates when 1
- data_in  in  NCH*WIDTH  packed signed samples; channel k at [k*WIDTH +: WIDTH]
- baseline_out  out  NCH*WIDTH  packed signed baselines
- baseline_valid  out  NCH  channel holds a baseline from a completed average
- cur_ch  out  $clog2(NCH)  channel currently owning the accumulator
- busy  out  1  not IDLE
- pass_done  out  1  one-cycle pulse at end of each pass
- cfg_error  out  1  sticky; start seen with ch_enable == 0

Behaviour:
- Reset: all outputs 0; accumulator and counters 0; state IDLE.
- States: IDLE, SELECT, SETTLE, ACCUM, LATCH, NEXT.
- IDLE:
  - start with ch_enable != 0 goes to SELECT, scanning from channel 0.
  - start with ch_enable == 0 sets cfg_error and stays in IDLE.
  - start while busy is ignored.
- SELECT (1 cycle):
  - Picks the lowest enabled index >= scan pointer and drives cur_ch.
  - Clears the accumulator and the sample counter.
  - If no enabled index remains, goes to NEXT.
- SETTLE:
  - Counts sample_en strobes up to settle_samples, then goes to ACCUM.
  - settle_samples == 0 goes to ACCUM on the next cycle.
- ACCUM:
  - On each sample_en: acc += sign-extended data_in[cur_ch]; counter++.
  - When the counter reaches 2^AVG_LOG2, goes to LATCH.
  - Exactly 2^AVG_LOG2 samples are summed.
- LATCH (1 cycle):
  - baseline_out[cur_ch] = acc[WIDTH+AVG_LOG2-1 -: WIDTH], an arithmetic divide truncated toward -inf.
  - baseline_valid[cur_ch] <= 1.
  - Scan pointer = cur_ch+1; back to SELECT.
- NEXT (1 cycle):
  - Pulses pass_done.
  - If continuous, re-enters SELECT at pointer 0; otherwise goes to IDLE.
- Accumulator width: WIDTH+AVG_LOG2 bits signed; no overflow is possible.
- Mapping:
  - busy = (state != IDLE).
  - pass_done is a registered pulse in the NEXT cycle.
  - baseline_out updates the cycle after LATCH.
- ch_enable is sampled only in SELECT. Disabling a channel mid-average does not cut that average short.
- A sample_en landing in the LATCH, SELECT or NEXT cycle is dropped, not counted.
- abort:
  - Any state goes to IDLE the next cycle; the in-progress sum is discarded.
  - baseline_out and baseline_valid are retained; no pass_done.
- abort and start in the same cycle: abort wins.
- reset mid-pass: full reset, which clears baseline_valid and baseline_out.
- cfg_error clears only on reset or on a start with valid ch_enable.
- Latency, one channel, settle S: 1 (SELECT) + S strobes + 2^AVG_LOG2 strobes + 1 (LATCH).

Optional Feature:
- Macro: BASELINE_SCHED_ROUNDING_EN.
- Defined: LATCH adds 2^(AVG_LOG2-1) to acc before truncation (round half up). The rounded sum uses WIDTH+AVG_LOG2+1 bits, then saturates to the WIDTH signed range.
- Undefined: plain truncation as above; no extra adder.

Decomposition:
- Package baseline_sched_pkg holds:
  - state enum sched_state_t;
  - function clog2-based channel index width;
  - localparam for the accumulator width.
- One sub-module, baseline_accumulator:
  - clear, add-enable and data inputs;
  - sum and count outputs;
  - reached-N flag.
- The scheduler FSM, channel mux and baseline register file stay in the top.

Test Plan:
- Reset, NCH=4, AVG_LOG2=4, settle 2, all channels constant: ch0=100, ch1=-50, ch2=0, ch3=2047.
  - start -> baselines 100, -50, 0, 2047.
  - baseline_valid = 4'b1111; one pass_done; busy drops after NEXT.
- ch_enable = 4'b0101 -> only ch0 and ch2 latched; baseline_valid = 4'b0101; cur_ch never shows 1 or 3.
- ch0 alternates -3/-2, AVG_LOG2=4 -> sum -40.
  - Without the macro: baseline -3.
  - With BASELINE_SCHED_ROUNDING_EN: -2.
- abort mid-ACCUM on ch1, after ch0 latched.
  - Result: IDLE next cycle; baseline_valid = 4'b0001; ch0 value kept; no pass_done.
- start with ch_enable = 0 -> cfg_error = 1, busy stays 0; next valid start clears cfg_error.
- continuous = 1 with a step on ch2 from 10 to 20 -> the second pass updates ch2 to 20; pass_done pulses once per pass.
